// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Accepts one request at a time, waits an opcode-dependent time, then holds the response until it is consumed.
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_opcode,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_opcode,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic [2:0]           alu_opcode,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 busy
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [2:0]    OP_SUM  = 3'b000;
    localparam logic [2:0]    OP_PRO  = 3'b010;
    localparam logic [CW-1:0] LAT_PRO = CW'(MUL_LAT);
    localparam logic [CW-1:0] LAT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAP,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last_grant;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_alu_opcode;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_result;
    logic                 r_rsp_carry;
    logic                 r_rsp_zero;

    logic                 w_winner;
    logic                 w_idle;
    logic                 w_accept;
    logic [2:0]           w_sel_opcode;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;

    // When both requesters are waiting, the one not served last time wins.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_grant;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    assign w_idle       = (r_state == S_IDLE) && !rst;
    assign req0_ready   = w_idle && req0_valid && !w_winner;
    assign req1_ready   = w_idle && req1_valid && w_winner;
    assign w_accept     = req0_ready || req1_ready;
    assign w_sel_opcode = w_winner ? req1_opcode : req0_opcode;
    assign w_sel_a      = w_winner ? req1_a : req0_a;
    assign w_sel_b      = w_winner ? req1_b : req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)         w_next = S_EXEC;
            S_EXEC: if (r_cnt == LAT_ONE) w_next = S_CAP;
            S_CAP:                        w_next = S_RESP;
            S_RESP: if (rsp_ready)        w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_opcode <= w_sel_opcode;
                r_alu_a      <= w_sel_a;
                r_alu_b      <= w_sel_b;
                r_rsp_id     <= w_winner;
                r_last_grant <= w_winner;
                r_cnt        <= (w_sel_opcode == OP_PRO) ? LAT_PRO : LAT_ONE;
            end
            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - LAT_ONE;
            end
            // Carry is only meaningful for SUM; every other opcode reports it as 0.
            if (r_state == S_CAP) begin
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
                r_rsp_carry  <= (r_alu_opcode == OP_SUM) ? alu_carry : 1'b0;
                r_rsp_valid  <= 1'b1;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed scoreboard bench for alu_req_arbiter
// Models the ALU (combinational result, registered flags) and predicts each response at accept time.
module tb_alu_req_arbiter;

    localparam int W  = 8;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]     req0_opcode, req1_opcode, alu_opcode;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [2*W-1:0] alu_result, rsp_result;
    logic           alu_carry, alu_zero;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic           id;
        logic [2*W-1:0] res;
        logic           c;
        logic           z;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];

    alu_req_arbiter #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] xa, xb;
        xa = {{W{1'b0}}, a};
        xb = {{W{1'b0}}, b};
        case (op)
            3'b000:  return xa + xb;
            3'b001:  return xa - xb;
            3'b010:  return xa * xb;
            3'b011:  return xa & xb;
            3'b100:  return xa | xb;
            3'b101:  return {{W{1'b0}}, ~(a & b)};
            3'b110:  return {{W{1'b0}}, ~(a | b)};
            default: return xa ^ xb;
        endcase
    endfunction

    // Flag register raises carry on bit W for every op, so the DUT's SUM-only masking is visible.
    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
    always @(posedge clk) begin
        if (rst) begin
            alu_carry <= 1'b0;
            alu_zero  <= 1'b0;
        end else begin
            alu_carry <= alu_result[W];
            alu_zero  <= (alu_result == '0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.res = alu_f(op, a, b);
        e.c   = (op == 3'b000) ? e.res[W] : 1'b0;
        e.z   = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: push at accept, pop and compare at response handshake, flush on reset.
    always @(negedge clk) begin
        exp_t e;
        chk("single_ready", 32'(req0_ready & req1_ready), 32'(0));
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back(predict(1'b0, req0_opcode, req0_a, req0_b));
                grant_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(predict(1'b1, req1_opcode, req1_a, req1_b));
                grant_log.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_id",     32'(rsp_id),     32'(e.id));
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_carry",  32'(rsp_carry),  32'(e.c));
                    chk("rsp_zero",   32'(rsp_zero),   32'(e.z));
                end
            end
        end
    end

    task automatic drive(input bit id, input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic rdy(input bit id);
        return id ? req1_ready : req0_ready;
    endfunction

    task automatic wait_ready(input bit id, input string tag);
        int n = 0;
        @(negedge clk);
        while (!rdy(id) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(rdy(id)), 32'(1));
    endtask

    task automatic run_op(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input string tag);
        int n = 0;
        bit seen = 0;
        drive(id, 1'b1, op, a, b);
        wait_ready(id, tag);
        @(posedge clk); #1;
        drive(id, 1'b0, op, a, b);
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = rsp_valid;
        end
        chk({tag, "_latency"}, 32'(seen ? n : -1), 32'(lat));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy || rsp_valid) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_drained"}, 32'(sb.size() == 0 && !busy), 32'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu"},  {alu_opcode, alu_a, alu_b}, 32'(0));
        chk({tag, "_rsp"},  {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result}, 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_rdy"},  32'({req0_ready, req1_ready}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] s_res;
        logic           s_id, s_c, s_z;
        int             n, rises;

        rst = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);

        // Reset: a valid request must not see ready while rst is high.
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 8'd1, 8'd1);
        @(negedge clk);
        chk("rst_ready_gated", 32'(req0_ready), 32'(0));
        drive(1'b0, 1'b0, 3'b000, 8'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // 1: SUM 200+100 with 8-bit overflow carry.
        rsp_ready = 1'b1;
        run_op(1'b0, 3'b000, 8'd200, 8'd100, 2, "t1_sum");

        // 2: PRO 12*13 from req1.
        run_op(1'b1, 3'b010, 8'd12, 8'd13, ML + 1, "t2_pro");

        // 3: both requesters hold RES requests; grants must alternate starting with req0.
        grant_log.delete();
        drive(1'b0, 1'b1, 3'b001, 8'd50, 8'd20);
        drive(1'b1, 1'b1, 3'b001, 8'd10, 8'd30);
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b001, 8'd50, 8'd20);
        drive(1'b1, 1'b0, 3'b001, 8'd10, 8'd30);
        wait_idle("t3");
        chk("t3_grant_count", 32'(grant_log.size()), 32'(4));
        if (grant_log.size() == 4) begin
            chk("t3_grant_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 32'(4'b0101));
        end

        // 4: XOR of equal operands gives zero flag.
        run_op(1'b0, 3'b111, 8'h5A, 8'h5A, 2, "t4_xor");

        // 5: consumer stalls for 10 cycles; response and arbiter hold, req1 waits.
        rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b011, 8'hF0, 8'h3C);
        wait_ready(1'b0, "t5");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b011, 8'hF0, 8'h3C);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("t5_rsp_valid", 32'(rsp_valid), 32'(1));
        s_res = rsp_result; s_id = rsp_id; s_c = rsp_carry; s_z = rsp_zero;
        drive(1'b1, 1'b1, 3'b100, 8'h81, 8'h18);
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold", {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result, busy, req1_ready},
                {1'b1, s_id, s_c, s_z, s_res, 1'b1, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_back_idle", 32'({busy, rsp_valid, req1_ready}), 32'(3'b001));
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b100, 8'h81, 8'h18);
        wait_idle("t5");

        // 6: reset in the middle of a PRO; nothing comes out, req0 wins first afterwards.
        drive(1'b0, 1'b1, 3'b010, 8'd7, 8'd9);
        wait_ready(1'b0, "t6");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b010, 8'd7, 8'd9);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        rises = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) rises++;
        end
        chk("t6_no_rsp", 32'(rises), 32'(0));
        grant_log.delete();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 3'b000, 8'd3, 8'd4);
        drive(1'b0, 1'b1, 3'b000, 8'd1, 8'd2);
        @(negedge clk);
        chk("t6_first_grant", 32'({req0_ready, req1_ready}), 32'(2'b10));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 8'd1, 8'd2);
        n = 0;
        while (grant_log.size() < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b000, 8'd3, 8'd4);
        wait_idle("t6");
        chk("t6_grants", 32'(grant_log.size()), 32'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
